// File: rtl/maze_link_pkg.sv
// Shared definitions for MAZE fabric torus links: packet layout, width helpers
// and the lane identifiers used by the virtual-lane merge.
package maze_link_pkg;

    localparam int DEPTH_MAX  = 7;
    localparam int NODE_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    function automatic int pkt_w(input int node_w, input int data_w);
        return 2 + 1 + 2 * node_w + data_w;
    endfunction

    // A zero-depth link holds nothing, but a port still needs one bit.
    function automatic int occ_w(input int depth);
        return (depth == 0) ? 1 : $clog2(4 * depth + 1);
    endfunction

    localparam int PKT_W_DEF = pkt_w(NODE_W_DEF, DATA_W_DEF);
    localparam int TYPE_LSB  = PKT_W_DEF - 2;
    localparam int QOS_BIT   = PKT_W_DEF - 3;
    localparam int SRC_LSB   = QOS_BIT - NODE_W_DEF;
    localparam int TGT_LSB   = SRC_LSB - NODE_W_DEF;

    typedef struct packed {
        logic [1:0]            typ;
        logic                  qos;
        logic [NODE_W_DEF-1:0] src;
        logic [NODE_W_DEF-1:0] tgt;
        logic [DATA_W_DEF-1:0] data;
    } pkt_t;

    typedef enum logic {
        LANE_Q0 = 1'b0,
        LANE_Q1 = 1'b1
    } lane_e;

endpackage

// File: rtl/torus_link_slice.sv
// One pipeline slice of a torus link lane: 2-entry skid buffer with a
// registered ready, one cycle of latency and full throughput.
module torus_link_slice #(
    parameter int PKT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [PKT_W-1:0] pkt_i,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [PKT_W-1:0] pkt_o
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [PKT_W-1:0] main_q, main_d;
    logic [PKT_W-1:0] skid_q, skid_d;
    logic             push, pop;

    assign rdy_o = !skid_vld_q;
    assign vld_o = main_vld_q;
    assign pkt_o = main_q;

    always_comb begin
        push       = vld_i && !skid_vld_q;
        pop        = main_vld_q && rdy_i;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (push) begin
            // The skid entry only fills when the output side is stalled.
            if (!main_vld_q || pop) begin
                main_d     = pkt_i;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = pkt_i;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/torus_link_vc.sv
// Directed torus link with two QoS lanes of DEPTH skid slices each, merged at
// the sink by starvation-limited strict priority (QoS1 preferred).
module torus_link_vc
    import maze_link_pkg::*;
#(
    parameter int NODE_W     = 6,
    parameter int DATA_W     = 8,
    parameter int PKT_W      = pkt_w(NODE_W, DATA_W),
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [PKT_W-1:0]        in_pkt,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [PKT_W-1:0]        out_pkt,
    output logic [occ_w(DEPTH)-1:0] occ,
    output logic [CNT_W-1:0]        xfer_cnt,
    output logic                    starve_hit
);

    localparam int         OCC_W = occ_w(DEPTH);
    localparam logic [7:0] LIM   = 8'(STARVE_LIM);

    if (DEPTH < 0 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("torus_link_vc: DEPTH %0d outside 0..%0d", DEPTH, DEPTH_MAX);
    end
    if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_bad_lim
        $error("torus_link_vc: STARVE_LIM %0d outside 1..255", STARVE_LIM);
    end
    if (PKT_W != pkt_w(NODE_W, DATA_W)) begin : g_bad_pkt_w
        $error("torus_link_vc: PKT_W must equal 3+2*NODE_W+DATA_W");
    end

    logic [1:0]       head_vld, head_rdy, tail_rdy;
    logic [PKT_W-1:0] head_pkt [2];

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic             c_vld [DEPTH+1];
        logic             c_rdy [DEPTH+1];
        logic [PKT_W-1:0] c_pkt [DEPTH+1];

        // Index DEPTH is the lane tail, index 0 the head; with DEPTH=0 they coincide.
        assign c_vld[DEPTH] = in_vld && !rst && (in_pkt[PKT_W-3] == 1'(l));
        assign c_pkt[DEPTH] = in_pkt;
        assign tail_rdy[l]  = c_rdy[DEPTH];
        assign head_vld[l]  = c_vld[0];
        assign head_pkt[l]  = c_pkt[0];
        assign c_rdy[0]     = head_rdy[l];

        for (genvar s = 0; s < DEPTH; s++) begin : g_slice
            torus_link_slice #(.PKT_W(PKT_W)) u_slice (
                .clk   (clk),
                .rst   (rst),
                .vld_i (c_vld[s+1]),
                .rdy_o (c_rdy[s+1]),
                .pkt_i (c_pkt[s+1]),
                .vld_o (c_vld[s]),
                .rdy_i (c_rdy[s]),
                .pkt_o (c_pkt[s])
            );
        end
    end

    logic             lock_q, lock_d;
    lane_e            lock_lane_q, lock_lane_d;
    lane_e            grant;
    logic [7:0]       starve_cnt_q, starve_cnt_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             in_xfer, out_xfer;

    assign in_rdy   = !rst && (in_pkt[PKT_W-3] ? tail_rdy[1] : tail_rdy[0]);
    assign in_xfer  = in_vld && in_rdy;
    assign occ      = occ_q;
    assign xfer_cnt = xfer_cnt_q;

    always_comb begin
        grant      = LANE_Q0;
        starve_hit = 1'b0;
        if (lock_q) begin
            grant = lock_lane_q;
        end else if (head_vld[0] && head_vld[1]) begin
            if (starve_cnt_q == LIM) begin
                grant      = LANE_Q0;
                starve_hit = !rst;
            end else begin
                grant = LANE_Q1;
            end
        end else if (head_vld[1]) begin
            grant = LANE_Q1;
        end

        out_vld     = !rst && ((grant == LANE_Q1) ? head_vld[1] : head_vld[0]);
        out_pkt     = (grant == LANE_Q1) ? head_pkt[1] : head_pkt[0];
        head_rdy[0] = out_rdy && !rst && (grant == LANE_Q0);
        head_rdy[1] = out_rdy && !rst && (grant == LANE_Q1);
        out_xfer    = out_vld && out_rdy;

        lock_d       = lock_q;
        lock_lane_d  = lock_lane_q;
        starve_cnt_d = starve_cnt_q;
        xfer_cnt_d   = xfer_cnt_q;
        occ_d        = occ_q;

        if (out_vld && !out_rdy) begin
            lock_d      = 1'b1;
            lock_lane_d = grant;
        end else if (out_xfer) begin
            lock_d = 1'b0;
        end

        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            if (grant == LANE_Q0) begin
                starve_cnt_d = '0;
            end else if (head_vld[0] && starve_cnt_q != LIM) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end

        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (DEPTH == 0) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_lane_q  <= LANE_Q0;
            starve_cnt_q <= '0;
            occ_q        <= '0;
            xfer_cnt_q   <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_lane_q  <= lock_lane_d;
            starve_cnt_q <= starve_cnt_d;
            occ_q        <= occ_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

endmodule

// File: tb/tb_torus_link_vc.sv
// Bench for torus_link_vc: directed scenarios on four link configurations plus
// a randomized run checked against a queue-based lane/merge reference model.
module tb_torus_link_vc;
    import maze_link_pkg::*;

    localparam int PW     = 23;
    localparam int C_DEPTH = 2;
    localparam int C_LIM   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    // a: DEPTH=3, b: DEPTH=1, c: DEPTH=2 STARVE_LIM=2, z: DEPTH=0 CNT_W=4
    logic          a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_hit;
    logic [PW-1:0] a_in_pkt, a_out_pkt;
    logic [3:0]    a_occ;
    logic [31:0]   a_xfer;
    logic          b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_hit;
    logic [PW-1:0] b_in_pkt, b_out_pkt;
    logic [2:0]    b_occ;
    logic [31:0]   b_xfer;
    logic          c_in_vld, c_in_rdy, c_out_vld, c_out_rdy, c_hit;
    logic [PW-1:0] c_in_pkt, c_out_pkt;
    logic [3:0]    c_occ;
    logic [31:0]   c_xfer;
    logic          z_in_vld, z_in_rdy, z_out_vld, z_out_rdy, z_hit;
    logic [PW-1:0] z_in_pkt, z_out_pkt;
    logic [0:0]    z_occ;
    logic [3:0]    z_xfer;

    torus_link_vc #(.DEPTH(3), .STARVE_LIM(4)) u_a (
        .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_pkt(a_in_pkt),
        .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_pkt(a_out_pkt),
        .occ(a_occ), .xfer_cnt(a_xfer), .starve_hit(a_hit));
    torus_link_vc #(.DEPTH(1), .STARVE_LIM(4)) u_b (
        .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_pkt(b_in_pkt),
        .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_pkt(b_out_pkt),
        .occ(b_occ), .xfer_cnt(b_xfer), .starve_hit(b_hit));
    torus_link_vc #(.DEPTH(C_DEPTH), .STARVE_LIM(C_LIM)) u_c (
        .clk(clk), .rst(rst), .in_vld(c_in_vld), .in_rdy(c_in_rdy), .in_pkt(c_in_pkt),
        .out_vld(c_out_vld), .out_rdy(c_out_rdy), .out_pkt(c_out_pkt),
        .occ(c_occ), .xfer_cnt(c_xfer), .starve_hit(c_hit));
    torus_link_vc #(.DEPTH(0), .STARVE_LIM(4), .CNT_W(4)) u_z (
        .clk(clk), .rst(rst), .in_vld(z_in_vld), .in_rdy(z_in_rdy), .in_pkt(z_in_pkt),
        .out_vld(z_out_vld), .out_rdy(z_out_rdy), .out_pkt(z_out_pkt),
        .occ(z_occ), .xfer_cnt(z_xfer), .starve_hit(z_hit));

    function automatic logic [PW-1:0] mk_pkt(input logic q, input logic [7:0] d);
        pkt_t p;
        p.typ  = 2'b01;
        p.qos  = q;
        p.src  = 6'h0a;
        p.tgt  = 6'h15;
        p.data = d;
        return p;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {a_in_vld, a_out_rdy, b_in_vld, b_out_rdy} = '0;
        {c_in_vld, c_out_rdy, z_in_vld, z_out_rdy} = '0;
        a_in_pkt = '0; b_in_pkt = '0; c_in_pkt = '0; z_in_pkt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {a_in_vld, a_out_rdy, b_in_vld, b_out_rdy} = '0;
        {c_in_vld, c_out_rdy, z_in_vld, z_out_rdy} = '0;
        a_in_pkt = '0; b_in_pkt = '0; c_in_pkt = '0; z_in_pkt = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        tests++;
        if (c_in_rdy !== 1'b0) begin fails++; $display("FAIL rst_in_rdy_during: got %b expected 0", c_in_rdy); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (c_in_rdy !== 1'b1) begin fails++; $display("FAIL rst_in_rdy_after: got %b expected 1", c_in_rdy); end
        tests++;
        if (c_out_vld !== 1'b0) begin fails++; $display("FAIL rst_out_vld: got %b expected 0", c_out_vld); end
        tests++;
        if (c_occ !== 4'd0) begin fails++; $display("FAIL rst_occ: got %0d expected 0", c_occ); end
        tests++;
        if (c_xfer !== 32'd0) begin fails++; $display("FAIL rst_xfer_cnt: got %0d expected 0", c_xfer); end
        tests++;
        if (c_hit !== 1'b0) begin fails++; $display("FAIL rst_starve_hit: got %b expected 0", c_hit); end
        next_cycle();
    endtask

    task automatic test_latency();
        int sent = 0;
        int got = 0;
        do_reset();
        a_out_rdy = 1'b1;
        for (int t = 0; t < 20; t++) begin
            a_in_vld = (sent < 10);
            a_in_pkt = mk_pkt(1'b0, 8'(sent));
            @(negedge clk);
            if (a_in_vld) begin
                tests++;
                if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL lat_in_rdy t=%0d: got %b expected 1", t, a_in_rdy); end
            end
            tests++;
            if (a_out_vld !== (t >= 3 && t < 13)) begin
                fails++; $display("FAIL lat_out_vld t=%0d: got %b expected %b", t, a_out_vld, (t >= 3 && t < 13));
            end
            if (a_out_vld) begin
                tests++;
                if (a_out_pkt !== mk_pkt(1'b0, 8'(got))) begin
                    fails++; $display("FAIL lat_out_pkt t=%0d: got %h expected %h", t, a_out_pkt, mk_pkt(1'b0, 8'(got)));
                end
                got++;
            end
            if (a_in_vld && a_in_rdy) sent++;
            next_cycle();
        end
        a_in_vld = 1'b0;
        tests++;
        if (a_xfer !== 32'd10) begin fails++; $display("FAIL lat_xfer_cnt: got %0d expected 10", a_xfer); end
        tests++;
        if (a_occ !== 4'd0) begin fails++; $display("FAIL lat_occ: got %0d expected 0", a_occ); end
    endtask

    task automatic test_priority();
        logic       qs [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] ds [7] = '{8'd1, 8'h80, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        logic [7:0] ex [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'h80, 8'd5, 8'd6};
        int sent = 0;
        int got = 0;
        logic exp_hit;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            b_out_rdy = (t >= 3);
            b_in_vld  = (sent < 7);
            b_in_pkt  = (sent < 7) ? mk_pkt(qs[sent], ds[sent]) : '0;
            @(negedge clk);
            if (t < 3) begin
                tests++;
                if (b_in_rdy !== 1'b1) begin fails++; $display("FAIL prio_preload_rdy t=%0d: got %b expected 1", t, b_in_rdy); end
            end
            exp_hit = b_out_vld && b_out_rdy && (got == 4);
            tests++;
            if (b_hit !== exp_hit) begin fails++; $display("FAIL prio_starve_hit t=%0d: got %b expected %b", t, b_hit, exp_hit); end
            if (b_out_vld && b_out_rdy && got < 7) begin
                tests++;
                if (b_out_pkt[7:0] !== ex[got]) begin
                    fails++; $display("FAIL prio_order #%0d: got %h expected %h", got, b_out_pkt[7:0], ex[got]);
                end
                got++;
            end
            if (b_in_vld && b_in_rdy) sent++;
            next_cycle();
        end
        b_in_vld = 1'b0;
        tests++;
        if (b_xfer !== 32'd7) begin fails++; $display("FAIL prio_xfer_cnt: got %0d expected 7", b_xfer); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ex [2] = '{8'h11, 8'h22};
        int got = 0;
        do_reset();
        for (int t = 0; t < 15; t++) begin
            b_out_rdy = (t >= 6);
            b_in_vld  = (t < 2);
            b_in_pkt  = (t == 0) ? mk_pkt(1'b0, 8'h11) : mk_pkt(1'b1, 8'h22);
            @(negedge clk);
            if (t >= 1 && t <= 5) begin
                tests++;
                if (b_out_vld !== 1'b1 || b_out_pkt !== mk_pkt(1'b0, 8'h11)) begin
                    fails++; $display("FAIL bp_stable t=%0d: got vld=%b pkt=%h expected vld=1 pkt=%h", t, b_out_vld, b_out_pkt, mk_pkt(1'b0, 8'h11));
                end
            end
            if (b_out_vld && b_out_rdy && got < 2) begin
                tests++;
                if (b_out_pkt[7:0] !== ex[got]) begin
                    fails++; $display("FAIL bp_order #%0d: got %h expected %h", got, b_out_pkt[7:0], ex[got]);
                end
                got++;
            end
            next_cycle();
        end
        b_in_vld = 1'b0;
        tests++;
        if (got != 2) begin fails++; $display("FAIL bp_delivered: got %0d expected 2", got); end
    endtask

    task automatic test_isolation_and_reset();
        do_reset();
        c_in_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c_in_pkt = mk_pkt(1'b0, 8'(k));
            @(negedge clk);
            tests++;
            if (c_in_rdy !== 1'b1) begin fails++; $display("FAIL iso_q0_accept #%0d: got %b expected 1", k, c_in_rdy); end
            next_cycle();
        end
        c_in_pkt = mk_pkt(1'b0, 8'd4);
        @(negedge clk);
        tests++;
        if (c_in_rdy !== 1'b0) begin fails++; $display("FAIL iso_q0_full: got %b expected 0", c_in_rdy); end
        tests++;
        if (c_occ !== 4'd4) begin fails++; $display("FAIL iso_occ4: got %0d expected 4", c_occ); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            c_in_pkt = mk_pkt(1'b1, 8'(8'h40 + k));
            @(negedge clk);
            tests++;
            if (c_in_rdy !== 1'b1) begin fails++; $display("FAIL iso_q1_accept #%0d: got %b expected 1", k, c_in_rdy); end
            tests++;
            if (c_occ !== 4'(4 + k)) begin fails++; $display("FAIL iso_occ #%0d: got %0d expected %0d", k, c_occ, 4 + k); end
            next_cycle();
        end
        c_in_vld = 1'b0;
        @(negedge clk);
        tests++;
        if (c_occ !== 4'd6) begin fails++; $display("FAIL mid_occ6: got %0d expected 6", c_occ); end
        next_cycle();
        rst = 1'b1;
        c_in_vld = 1'b1;
        @(negedge clk);
        tests++;
        if (c_in_rdy !== 1'b0 || c_out_vld !== 1'b0) begin
            fails++; $display("FAIL mid_during_rst: got rdy=%b vld=%b expected 0 0", c_in_rdy, c_out_vld);
        end
        next_cycle();
        rst = 1'b0;
        c_in_vld = 1'b0;
        c_out_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if (c_occ !== 4'd0 || c_xfer !== 32'd0 || c_in_rdy !== 1'b1) begin
            fails++; $display("FAIL mid_after_rst: got occ=%0d xfer=%0d rdy=%b expected 0 0 1", c_occ, c_xfer, c_in_rdy);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (c_out_vld !== 1'b0) begin fails++; $display("FAIL mid_discard #%0d: got out_vld %b expected 0", k, c_out_vld); end
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
    endtask

    task automatic test_passthrough();
        logic [PW-1:0] p;
        do_reset();
        z_in_vld  = 1'b1;
        z_in_pkt  = 23'h2ABCDE;
        z_out_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if (z_out_vld !== 1'b1 || z_out_pkt !== 23'h2ABCDE || z_in_rdy !== 1'b1) begin
            fails++; $display("FAIL pass_same_cycle: got vld=%b pkt=%h rdy=%b expected 1 2abcde 1", z_out_vld, z_out_pkt, z_in_rdy);
        end
        next_cycle();
        z_out_rdy = 1'b0;
        @(negedge clk);
        tests++;
        if (z_in_rdy !== 1'b0 || z_out_vld !== 1'b1) begin
            fails++; $display("FAIL pass_rdy_follows: got rdy=%b vld=%b expected 0 1", z_in_rdy, z_out_vld);
        end
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            p = PW'($urandom);
            z_in_pkt  = p;
            z_out_rdy = 1'b1;
            @(negedge clk);
            tests++;
            if (z_out_vld !== 1'b1 || z_out_pkt !== p || z_in_rdy !== 1'b1 || z_occ !== 1'b0) begin
                fails++; $display("FAIL pass_stream #%0d: got vld=%b pkt=%h rdy=%b occ=%0d expected 1 %h 1 0", k, z_out_vld, z_out_pkt, z_in_rdy, z_occ, p);
            end
            next_cycle();
        end
        z_in_vld = 1'b0;
        tests++;
        if (z_xfer !== 4'd1) begin fails++; $display("FAIL pass_xfer_wrap: got %0d expected 1", z_xfer); end
    endtask

    task automatic test_random();
        logic [PW-1:0] q0 [$];
        logic [PW-1:0] q1 [$];
        int a0 [$];
        int a1 [$];
        int ld0 = -100;
        int ld1 = -100;
        int sc = 0;
        int exp_x = 0;
        int av;
        int lane_sz;
        logic lock = 1'b0;
        logic lock_ln = 1'b0;
        logic h0v, h1v, g, ev, ehit;
        logic [PW-1:0] epkt;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            c_in_vld = ($urandom_range(3, 0) != 0);
            c_in_pkt = PW'($urandom);
            c_in_pkt[PW-3] = ($urandom_range(4, 0) < 3);
            c_out_rdy = ((cyc / 50) % 2 == 1) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            @(negedge clk);

            h0v = 1'b0;
            if (q0.size() > 0) begin
                av = (a0[0] + C_DEPTH > ld0 + 1) ? a0[0] + C_DEPTH : ld0 + 1;
                h0v = (av <= cyc);
            end
            h1v = 1'b0;
            if (q1.size() > 0) begin
                av = (a1[0] + C_DEPTH > ld1 + 1) ? a1[0] + C_DEPTH : ld1 + 1;
                h1v = (av <= cyc);
            end
            ehit = 1'b0;
            if (lock) g = lock_ln;
            else if (h0v && h1v) begin
                g = (sc != C_LIM);
                ehit = (sc == C_LIM);
            end else g = h1v;
            ev = g ? h1v : h0v;
            epkt = g ? ((q1.size() > 0) ? q1[0] : '0) : ((q0.size() > 0) ? q0[0] : '0);

            tests++;
            if (c_out_vld !== ev) begin fails++; $display("FAIL rand_out_vld c=%0d: got %b expected %b", cyc, c_out_vld, ev); end
            if (ev) begin
                tests++;
                if (c_out_pkt !== epkt) begin fails++; $display("FAIL rand_out_pkt c=%0d: got %h expected %h", cyc, c_out_pkt, epkt); end
            end
            tests++;
            if (c_hit !== ehit) begin fails++; $display("FAIL rand_starve_hit c=%0d: got %b expected %b", cyc, c_hit, ehit); end
            tests++;
            if (c_occ !== 4'(q0.size() + q1.size())) begin
                fails++; $display("FAIL rand_occ c=%0d: got %0d expected %0d", cyc, c_occ, q0.size() + q1.size());
            end
            tests++;
            if (c_xfer !== 32'(exp_x)) begin fails++; $display("FAIL rand_xfer_cnt c=%0d: got %0d expected %0d", cyc, c_xfer, exp_x); end
            lane_sz = c_in_pkt[PW-3] ? q1.size() : q0.size();
            tests++;
            if ((c_in_rdy && lane_sz >= 2 * C_DEPTH) || (!c_in_rdy && lane_sz == 0)) begin
                fails++; $display("FAIL rand_in_rdy c=%0d: got %b with %0d queued in lane", cyc, c_in_rdy, lane_sz);
            end

            if (ev && c_out_rdy) begin
                exp_x++;
                if (g) begin
                    void'(q1.pop_front()); void'(a1.pop_front()); ld1 = cyc;
                    if (h0v && sc < C_LIM) sc++;
                end else begin
                    void'(q0.pop_front()); void'(a0.pop_front()); ld0 = cyc;
                    sc = 0;
                end
            end
            if (ev && !c_out_rdy) begin
                lock = 1'b1;
                lock_ln = g;
            end else if (ev && c_out_rdy) lock = 1'b0;
            if (c_in_vld && c_in_rdy) begin
                if (c_in_pkt[PW-3]) begin q1.push_back(c_in_pkt); a1.push_back(cyc); end
                else begin q0.push_back(c_in_pkt); a0.push_back(cyc); end
            end
            next_cycle();
        end
        c_in_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_backpressure();
        test_isolation_and_reset();
        test_passthrough();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
